ha_serial_adder: RTL and testbench

- Bit-serial ripple adder that sits directly downstream of the tt_um_ha half-adder stage.
- Extends the single-bit sum/carry into a WIDTH-bit add by registering the carry between cycles.
- Operand bits arrive LSB-first, one pair per accepted cycle. Per-bit sum is streamed out; the assembled word, carry-out and signed overflow are presented at end of word.

---
 rtl/ha_serial_adder.sv | 136 +++++++++++++
 tb/tb_ha_serial_adder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_adder.sv
// Bit-serial WIDTH-bit ripple adder fed LSB-first by the half-adder stage.
// Optional macro HA_SERIAL_SUB_EN adds a 'sub' port for two's-complement A-B.
module ha_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic             in_start,
  input  logic             a_bit,
  input  logic             b_bit,
`ifdef HA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  output logic             sum_bit,
  output logic             word_done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             sum_bit_q, sum_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             word_done_q, word_done_d;

  logic accept, consume, last_bit;
  logic b_eff, c_in, s, c_next;

`ifdef HA_SERIAL_SUB_EN
  logic sub_q, sub_d, sub_eff;
  // The subtract mode is latched with bit 0 and held for the whole word.
  assign sub_eff = in_start ? sub : sub_q;
  assign b_eff   = b_bit ^ sub_eff;
  assign c_in    = in_start ? sub_eff : carry_q;
  assign sub_d   = (accept && in_start) ? sub : sub_q;
`else
  assign b_eff   = b_bit;
  assign c_in    = in_start ? 1'b0 : carry_q;
`endif

  assign s        = a_bit ^ b_eff ^ c_in;
  assign c_next   = (a_bit & b_eff) | (a_bit & c_in) | (b_eff & c_in);
  assign accept   = ena & in_valid;
  assign consume  = accept & (in_start | (state_q == ACCUM));
  assign last_bit = (state_q == ACCUM) & ~in_start & (cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    sum_bit_d   = sum_bit_q;
    out_valid_d = consume;
    word_done_d = 1'b0;
    if (consume) begin
      sum_bit_d = s;
      carry_d   = c_next;
      state_d   = ACCUM;
      if (in_start) begin
        shreg_d = {s, {(WIDTH-1){1'b0}}};
        cnt_d   = CW'(1);
      end else begin
        shreg_d = {s, shreg_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
      end
      if (last_bit) begin
        result_d    = {s, shreg_q[WIDTH-1:1]};
        carry_out_d = c_next;
        overflow_d  = c_in ^ c_next;
        word_done_d = 1'b1;
        cnt_d       = '0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      sum_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      word_done_q <= 1'b0;
`ifdef HA_SERIAL_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      sum_bit_q   <= sum_bit_d;
      out_valid_q <= out_valid_d;
      word_done_q <= word_done_d;
`ifdef HA_SERIAL_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  // Pulses are gated so a freshly dropped ena suppresses them immediately.
  assign out_valid = out_valid_q & ena;
  assign word_done = word_done_q & ena;
  assign sum_bit   = sum_bit_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == ACCUM);

endmodule

// File: tb/tb_ha_serial_adder.sv
// Self-checking bench for ha_serial_adder: directed scenarios plus random words
// checked against an arithmetic word-level reference model.
module tb_ha_serial_adder;
  localparam int W = 8;
`ifdef HA_SERIAL_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk, rst_n, ena, in_valid, in_start, a_bit, b_bit, sub_drv;
  logic         out_valid, sum_bit, word_done, carry_out, overflow, busy;
  logic [W-1:0] result;

  ha_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
    .in_start(in_start), .a_bit(a_bit), .b_bit(b_bit),
`ifdef HA_SERIAL_SUB_EN
    .sub(sub_drv),
`endif
    .out_valid(out_valid), .sum_bit(sum_bit), .word_done(word_done),
    .result(result), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_busy, m_consumed, m_done, m_sum, m_sub, m_cout, m_ovf;
  int          m_idx;
  logic [63:0] m_a, m_b, m_res;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_a = '0; m_b = '0; m_sub = 0;
    m_res = '0; m_cout = 0; m_ovf = 0; m_sum = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input bit st, input bit a, input bit b);
    logic [63:0] full;
    longint sa, sb, sv;
    m_consumed = 0;
    m_done     = 0;
    if (en && v) begin
      if (st) begin
        m_busy = 1; m_idx = 0; m_a = '0; m_b = '0;
        m_sub = HAS_SUB && sub_drv;
        m_consumed = 1;
      end else if (m_busy) m_consumed = 1;
    end
    if (m_consumed) begin
      m_a[m_idx] = a;
      m_b[m_idx] = b ^ m_sub;
      full  = m_a + m_b + 64'(m_sub);
      m_sum = full[m_idx];
      if (m_idx == W-1) begin
        m_done = 1;
        m_res  = full & ((64'd1 << W) - 1);
        m_cout = full[W];
        sa = longint'(m_a);
        sb = longint'(m_b);
        if (m_a[W-1]) sa = sa - (longint'(1) << W);
        if (m_b[W-1]) sb = sb - (longint'(1) << W);
        sv = sa + sb + longint'(m_sub);
        m_ovf  = (sv >= (longint'(1) << (W-1))) || (sv < -(longint'(1) << (W-1)));
        m_busy = 0;
      end else m_idx++;
    end
  endtask

  task automatic cyc(input bit en, input bit v, input bit st, input bit a, input bit b);
    ena = en; in_valid = v; in_start = st; a_bit = a; b_bit = b;
    @(posedge clk);
    #1;
    model_step(en, v, st, a, b);
    check("out_valid", 64'(out_valid), 64'(m_consumed));
    if (m_consumed) check("sum_bit", 64'(sum_bit), 64'(m_sum));
    check("word_done", 64'(word_done), 64'(m_done));
    check("result", 64'(result), m_res);
    check("carry_out", 64'(carry_out), 64'(m_cout));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("busy", 64'(busy), 64'(m_busy));
  endtask

  task automatic word(input logic [63:0] a, input logic [63:0] b, input bit s);
    sub_drv = s;
    for (int i = 0; i < W; i++) cyc(1, 1, i == 0, a[i], b[i]);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [7:0]  stream;
    rst_n = 0; ena = 0; in_valid = 0; in_start = 0; a_bit = 0; b_bit = 0; sub_drv = 0;
    model_reset();
    #12;
    check("rst_result", 64'(result), 64'd0);
    check("rst_outs", {58'd0, out_valid, sum_bit, word_done, carry_out, overflow, busy}, 64'd0);
    rst_n = 1;
    cyc(1, 0, 0, 0, 0);

    // 0x3C + 0x05, with explicit sum-bit stream capture
    ra = 64'h3C; rb = 64'h05;
    for (int i = 0; i < W; i++) begin
      cyc(1, 1, i == 0, ra[i], rb[i]);
      stream[i] = sum_bit;
    end
    check("stream_3c05", 64'(stream), 64'h41);
    check("res_3c05", 64'(result), 64'h41);
    check("done_3c05", 64'(word_done), 64'd1);
    cyc(1, 0, 0, 0, 0);
    check("done_width", 64'(word_done), 64'd0);

    // back-to-back words: 0xFF+0x01 then 0x7F+0x01
    word(64'hFF, 64'h01, 0);
    check("res_ff01", {56'd0, result}, 64'h00);
    check("cout_ff01", 64'(carry_out), 64'd1);
    check("ovf_ff01", 64'(overflow), 64'd0);
    word(64'h7F, 64'h01, 0);
    check("res_7f01", {56'd0, result}, 64'h80);
    check("cout_7f01", 64'(carry_out), 64'd0);
    check("ovf_7f01", 64'(overflow), 64'd1);

    // 0x3C + 0x05 with valid stalls after bits 2 and 5, ena low after bit 3
    ra = 64'h3C; rb = 64'h05;
    for (int i = 0; i < W; i++) begin
      cyc(1, 1, i == 0, ra[i], rb[i]);
      if (i == 2 || i == 5) begin cyc(1, 0, 0, 1, 1); cyc(1, 0, 1, 1, 1); end
      if (i == 3) for (int k = 0; k < 3; k++) cyc(0, 1, k == 1, 1, 0);
    end
    check("res_stall", 64'(result), 64'h41);

    // restart aborts a partial 0xAA+0x55
    ra = 64'hAA; rb = 64'h55;
    for (int i = 0; i < 3; i++) cyc(1, 1, i == 0, ra[i], rb[i]);
    check("res_held", 64'(result), 64'h41);
    word(64'h01, 64'h01, 0);
    check("res_restart", 64'(result), 64'h02);

    // asynchronous reset mid-word
    for (int i = 0; i < 4; i++) cyc(1, 1, i == 0, 1'b1, 1'b0);
    #3 rst_n = 0;
    #1;
    model_reset();
    check("arst_outs", {58'd0, out_valid, sum_bit, word_done, carry_out, overflow, busy}, 64'd0);
    check("arst_result", 64'(result), 64'd0);
    #3 rst_n = 1;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 1'b1, 1'b1);
    word(64'h12, 64'h34, 0);
    check("res_after_rst", 64'(result), 64'h46);

`ifdef HA_SERIAL_SUB_EN
    word(64'h05, 64'h07, 1);
    check("res_sub57", 64'(result), 64'hFE);
    check("cout_sub57", 64'(carry_out), 64'd0);
    check("ovf_sub57", 64'(overflow), 64'd0);
    word(64'h80, 64'h01, 1);
    check("res_sub801", 64'(result), 64'h7F);
    check("cout_sub801", 64'(carry_out), 64'd1);
    check("ovf_sub801", 64'(overflow), 64'd1);
`endif

    // random words with random stalls, ena drops and occasional restarts
    for (int w = 0; w < 40; w++) begin
      ra = 64'($urandom_range(0, 255));
      rb = 64'($urandom_range(0, 255));
      sub_drv = 1'($urandom_range(0, 1));
      for (int i = 0; i < W; i++) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else cyc(1, 0, 1'($urandom), 1'($urandom), 1'($urandom));
          end
        end
        cyc(1, 1, (i == 0) || ($urandom_range(0, 39) == 0), ra[i], rb[i]);
      end
      if ($urandom_range(0, 2) == 0) cyc(1, 1, 0, 1'($urandom), 1'($urandom));
    end
    cyc(1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
